// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: byte stream -> big-endian words written from address 0.
// Optional trailer checksum enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int WCW = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_FIN,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [WCW-1:0]  word_cnt_q, word_cnt_d;
  logic [31:0]     shift_q, shift_d;
  logic [31:0]     len_q, len_d;
  logic [31:0]     mem_a_q, mem_a_d;
  logic [31:0]     mem_wd_q, mem_wd_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]     sum_q, sum_d;
`endif

  logic        xfer;
  logic        last_byte;
  logic [31:0] shifted;

  // Shared assembly register: holds the length, each data word and the checksum in turn.
  assign shifted   = {shift_q[23:0], in_data};
  assign last_byte = (byte_cnt_q == 2'd3);
  assign xfer      = in_valid & in_ready;

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    shift_d    = shift_q;
    len_d      = len_q;
    mem_a_d    = mem_a_q;
    mem_wd_d   = mem_wd_q;
    done_d     = done_q;
    err_d      = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    in_ready   = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LEN;
          done_d     = 1'b0;
          err_d      = 1'b0;
          byte_cnt_d = '0;
          word_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
        end
      end
      S_LEN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift_d    = shifted;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (last_byte) begin
            len_d = shifted;
            if (shifted == 32'd0)             state_d = S_FIN;
            else if (shifted > 32'(DEPTH))    state_d = S_ERR;
            else                              state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift_d    = shifted;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (last_byte) begin
            mem_wd_d = shifted;
            mem_a_d  = 32'(word_cnt_q) << 2;
            state_d  = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        mem_we     = 1'b1;
        word_cnt_d = word_cnt_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q + mem_wd_q;
`endif
        if (32'(word_cnt_q) + 32'd1 == len_q) state_d = S_FIN;
        else                                  state_d = S_DATA;
      end
      S_FIN: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        in_ready = 1'b1;
        if (in_valid) begin
          shift_d    = shifted;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (last_byte) begin
            if (shifted == sum_q) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_ERR;
            end
          end
        end
`else
        done_d  = 1'b1;
        state_d = S_IDLE;
`endif
      end
      S_ERR: begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the combinational block above uses blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      shift_q    <= '0;
      len_q      <= '0;
      mem_a_q    <= '0;
      mem_wd_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      shift_q    <= shift_d;
      len_q      <= len_d;
      mem_a_q    <= mem_a_d;
      mem_wd_q   <= mem_wd_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign mem_a  = mem_a_q;
  assign mem_wd = mem_wd_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed images, expected writes queued, checked by a monitor.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t sb[$];
  int  errors = 0;
  int  checks = 0;
  int  writes_seen = 0;
  int  writes_expected = 0;

  imem_loader #(.DEPTH(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_a    (mem_a),
    .mem_wd   (mem_wd),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    sb.push_back(w);
    writes_expected++;
  endtask

  // Monitor: every write pulse is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && mem_we === 1'b1) begin
      writes_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got a=%h wd=%h expected no write", mem_a, mem_wd);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("write_addr", mem_a, e.a);
        check("write_data", mem_wd, e.d);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_ready", in_ready, 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    @(negedge clk);
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("handshake_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], gap);
  endtask

  // Called right after the 4th byte of the last word was accepted.
  task automatic finish_load(input logic [31:0] trailer, input bit expect_ok);
    @(negedge clk);
    check("we_pulse", mem_we, 1);
    @(negedge clk);
    check("we_single", mem_we, 0);
    check("fin_busy", busy, 1);
    check("fin_done", done, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(trailer, 1'b0);
    @(negedge clk);
    if (expect_ok) begin
      check("cs_done", done, 1);
      check("cs_busy", busy, 0);
      check("cs_err", err, 0);
    end else begin
      check("cs_err_cycle_busy", busy, 1);
      @(negedge clk);
      check("cs_err", err, 1);
      check("cs_done", done, 0);
      check("cs_busy", busy, 0);
    end
`else
    @(negedge clk);
    check("done_set", done, expect_ok ? 1 : 0);
    check("done_busy", busy, 0);
    check("done_err", err, 0);
    check("done_trailer_unused", trailer, trailer);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset values and idle with valid data but no start.
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_wd", mem_wd, 0);
    rst = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_ready", in_ready, 0);
      check("idle_busy", busy, 0);
    end
    in_valid = 1'b0;

    // Two-word image without stalls.
    expect_write(32'h0, 32'h20080005);
    expect_write(32'h4, 32'hAC080004);
    pulse_start();
    send_word(32'h00000002, 1'b0);
    send_word(32'h20080005, 1'b0);
    send_word(32'hAC080004, 1'b0);
    finish_load(32'hCC100009, 1'b1);

    // Same image with gaps between every byte.
    expect_write(32'h0, 32'h20080005);
    expect_write(32'h4, 32'hAC080004);
    pulse_start();
    check("restart_done_cleared", done, 0);
    send_word(32'h00000002, 1'b1);
    send_word(32'h20080005, 1'b1);
    send_word(32'hAC080004, 1'b1);
    finish_load(32'hCC100009, 1'b1);

    // Empty image.
    pulse_start();
    send_word(32'h00000000, 1'b0);
    @(negedge clk);
    check("n0_fin_busy", busy, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(32'h00000000, 1'b0);
`endif
    @(negedge clk);
    check("n0_done", done, 1);
    check("n0_busy", busy, 0);

    // Oversize image is rejected without any write.
    pulse_start();
    send_word(32'h00000041, 1'b0);
    @(negedge clk);
    check("big_err_cycle_busy", busy, 1);
    @(negedge clk);
    check("big_err", err, 1);
    check("big_done", done, 0);
    check("big_busy", busy, 0);
    check("big_ready", in_ready, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum: words written, then error.
    expect_write(32'h0, 32'h20080005);
    expect_write(32'h4, 32'hAC080004);
    pulse_start();
    check("restart_err_cleared", err, 0);
    send_word(32'h00000002, 1'b0);
    send_word(32'h20080005, 1'b0);
    send_word(32'hAC080004, 1'b0);
    finish_load(32'hCC10000A, 1'b0);
`endif

    // Reset after 6 data bytes of a 3-word image, then a clean one-word load.
    expect_write(32'h0, 32'h11223344);
    pulse_start();
    send_word(32'h00000003, 1'b0);
    send_word(32'h11223344, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_we", mem_we, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_mem_a", mem_a, 0);
    check("mid_rst_mem_wd", mem_wd, 0);
    @(negedge clk);
    rst = 1'b0;
    expect_write(32'h0, 32'hCAFEF00D);
    pulse_start();
    send_word(32'h00000001, 1'b0);
    send_word(32'hCAFEF00D, 1'b0);
    finish_load(32'hCAFEF00D, 1'b1);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("write_count", writes_seen, writes_expected);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
